sliding_window_sequence_generator: RTL
======================================

# sliding_window_sequence_generator

Serial pattern source for the sliding-window sequence detector. On a start request it emits one frame of the detected language, 1100 (10)^rep 01, MSB-first on a single bit line, followed by a configurable run of idle zeros. It drives detector benches and board-level loopback, and with rep = 0 produces a deliberate non-matching frame, 110001.

## Interface
Parameters:
- RW, 4: width of the rep count; maximum body repetitions is 2^RW − 1.
- GAP_CYC, 2: number of forced-zero idle cycles after each frame; 0 is legal.

Ports:
- clk  in  1  clock; all logic on the posedge.
- rst_n  in  1  reset, synchronous, active-high. The name is kept from the codebase; asserted = 1.
- start  in  1  frame request; sampled only when ready = 1.
- rep  in  RW  body repeat count; latched on the accepted start.
- out  out  1  serial bit, registered.
- valid  out  1  high while out carries a frame bit.
- ready  out  1  start will be accepted at this edge.
- done  out  1  one-cycle pulse, coincident with the final frame bit.

## Operation
- Reset values: out = 0, valid = 0, done = 0, ready = 1, state IDLE.
- States:
  - IDLE: ready = 1. An accepted start goes to HEAD.
  - HEAD: emits 4 bits, 1,1,0,0.
  - BODY: emits rep pairs 1,0. Skipped when rep = 0.
  - TAIL: emits 2 bits, 0,1.
  - GAP: GAP_CYC cycles with out = 0 and valid = 0. Skipped when GAP_CYC = 0.
  - Then return to IDLE.
- Frame length N = 6 + 2·rep bits. valid = 1 for exactly N consecutive cycles.
- The bit index counter is sized to cover 2^RW·2 + 6. The latched rep is used for the whole frame; changes on rep mid-frame are ignored.
- ready = 1 in three cases:
  - in IDLE;
  - in the final TAIL bit cycle when GAP_CYC = 0;
  - in the last GAP cycle.
- A start accepted in either non-IDLE ready cycle launches the next frame with no bubble. Its first bit follows the previous frame's last bit, or last gap zero, directly.
- start while ready = 0 is ignored; there is no queuing.
- Reset asserted mid-frame: at that edge out = 0, valid = 0, done = 0, state IDLE. No partial tail is emitted.
- When reset and start are both high at the same edge, reset wins.

## Timing
- Latency: when start is accepted at edge E, the first bit (1) appears on out from edge E. It is visible in the cycle after E.
- Bit k (0-based) is driven from edge E + k. The last bit is driven from edge E + N − 1, with done = 1 in that same cycle.
- GAP zeros follow, driven from edges E + N through E + N + GAP_CYC − 1.
- out changes only on posedge. A consumer sampling at the next posedge, or at negedge as the detector bench does, sees stable bits.
- done never asserts outside a valid cycle.
- With rep = 2^RW − 1, the counter reaches its maximum without wrap, and the frame is exactly 6 + 2·(2^RW − 1) bits.

## Structure
- Shared package sequence_pkg holds:
  - constants SEQ_HEAD = 4'b1100, SEQ_BODY = 2'b10, SEQ_TAIL = 2'b01;
  - the state enum (IDLE, HEAD, BODY, TAIL, GAP).
- The detector side of the codebase imports the same package, so the language is defined once.
- One sub-module is natural: seq_bit_counter, a loadable down counter with a zero flag. It is reused for the per-state bit count and for GAP.
- The FSM and output register stay in the top module.

## Test plan
1. Reset, then start with rep = 1 (GAP_CYC = 2) → out = 1,1,0,0,1,0,0,1 with valid high for 8 cycles, done on the 8th, then 2 zeros, then ready = 1.
2. rep = 3 → 12-bit frame 110010101001. done occurs 11 cycles after the first bit.
3. rep = 0 → 110001 (6 bits). When looped into the detector, dec never asserts.
4. GAP_CYC = 0, start held high, rep = 1 → two frames back-to-back (16 valid cycles, no bubble). With loopback, the detector asserts dec once per frame.
5. Reset asserted at bit 5 of a rep = 2 frame → out = 0 and valid = 0 from that edge, ready = 1, no done pulse. Restarting yields a full, correct frame.
6. start pulsed at bit 3 (ready = 0), and rep changed mid-frame → both ignored. Frame length and content match the originally latched rep.

Source files
------------

// File: rtl/sequence_pkg.sv
// rtl/sequence_pkg.sv - shared frame language constants and generator state enum
package sequence_pkg;

  // Frame language: HEAD, then BODY repeated rep times, then TAIL (MSB first)
  localparam logic [3:0] SEQ_HEAD = 4'b1100;
  localparam logic [1:0] SEQ_BODY = 2'b10;
  localparam logic [1:0] SEQ_TAIL = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    BODY,
    TAIL,
    GAP
  } seq_state_t;

endpackage

// File: rtl/seq_bit_counter.sv
// rtl/seq_bit_counter.sv - loadable down counter with zero flag
module seq_bit_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/sliding_window_sequence_generator.sv
// rtl/sliding_window_sequence_generator.sv - emits 1100 (10)^rep 01 frames followed by idle gap
module sliding_window_sequence_generator
  import sequence_pkg::*;
#(
  parameter int RW      = 4,
  parameter int GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] rep,
  output logic          out,
  output logic          valid,
  output logic          ready,
  output logic          done
);

  // Counter covers the longest body load as well as the gap length
  localparam int CW       = $clog2((2**RW) * 2 + 6 + GAP_CYC + 1);
  localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  seq_state_t    r_state;
  seq_state_t    w_state_n;
  logic          r_out;
  logic          r_valid;
  logic          r_done;
  logic [RW-1:0] r_rep;
  logic          w_out_n;
  logic          w_valid_n;
  logic          w_done_n;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_dec;
  logic [CW-1:0] w_cnt;
  logic          w_zero;
  logic          w_accept;
  logic [1:0]    w_head_idx;
  logic [CW-1:0] w_body_load;

  // Counter holds bits remaining in the current state after this one
  seq_bit_counter #(.W(CW)) u_cnt (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (w_cnt),
    .o_zero     (w_zero)
  );

  assign ready = (r_state == IDLE)
               || ((r_state == TAIL) && w_zero && (GAP_CYC == 0))
               || ((r_state == GAP) && w_zero);
  assign w_accept    = ready && start;
  assign w_head_idx  = 2'(w_cnt - CW'(1));
  assign w_body_load = CW'({r_rep, 1'b0}) - CW'(1);

  // Next-state and next registered outputs; launch overrides the ready cycles
  always_comb begin
    w_state_n  = r_state;
    w_out_n    = 1'b0;
    w_valid_n  = 1'b0;
    w_done_n   = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      HEAD: begin
        w_valid_n = 1'b1;
        if (!w_zero) begin
          w_dec   = 1'b1;
          w_out_n = SEQ_HEAD[w_head_idx];
        end else if (r_rep != '0) begin
          w_state_n  = BODY;
          w_load     = 1'b1;
          w_load_val = w_body_load;
          w_out_n    = SEQ_BODY[1];
        end else begin
          w_state_n  = TAIL;
          w_load     = 1'b1;
          w_load_val = CW'(1);
          w_out_n    = SEQ_TAIL[1];
        end
      end
      BODY: begin
        w_valid_n = 1'b1;
        if (!w_zero) begin
          w_dec   = 1'b1;
          w_out_n = SEQ_BODY[~w_cnt[0]];
        end else begin
          w_state_n  = TAIL;
          w_load     = 1'b1;
          w_load_val = CW'(1);
          w_out_n    = SEQ_TAIL[1];
        end
      end
      TAIL: begin
        if (!w_zero) begin
          w_dec     = 1'b1;
          w_out_n   = SEQ_TAIL[0];
          w_valid_n = 1'b1;
          w_done_n  = 1'b1;
        end else if (GAP_CYC > 0) begin
          w_state_n  = GAP;
          w_load     = 1'b1;
          w_load_val = CW'(GAP_LOAD);
        end else begin
          w_state_n = IDLE;
        end
      end
      GAP: begin
        if (!w_zero) begin
          w_dec = 1'b1;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
    if (w_accept) begin
      w_state_n  = HEAD;
      w_load     = 1'b1;
      w_load_val = CW'(3);
      w_out_n    = SEQ_HEAD[3];
      w_valid_n  = 1'b1;
      w_done_n   = 1'b0;
    end
  end

  // State, output register and rep latch
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_rep   <= '0;
    end else begin
      r_state <= w_state_n;
      r_out   <= w_out_n;
      r_valid <= w_valid_n;
      r_done  <= w_done_n;
      if (w_accept) begin
        r_rep <= rep;
      end
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign done  = r_done;

endmodule
